otp_auth_core: RTL and testbench
================================

OTP_AUTH_CORE -- requirements
Module: otp_auth_core

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of OTP digits (legal 2..8); W = 4*DIGITS.
REQ-002 SHALL have parameter SEED, default 16'hACE1, LFSR reset value (W bits, non-zero).
REQ-003 SHALL have parameter TAPS, default 16'hB400, LFSR feedback mask (W bits, maximal-length for W).
REQ-004 SHALL have parameter MAX_ATTEMPTS, default 3, failed checks before lockout (legal 1..15).
REQ-005 SHALL have parameter LOCK_CYCLES, default 1000, lockout duration in clocks (legal >=1).
REQ-006 SHALL have parameter SCAN_DIV, default 4, clocks per display digit (legal >=1).
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have ports: otp_latch  in  1  generate/capture new OTP, start session.
REQ-010 SHALL have ports: user_latch  in  1  capture one user digit.
REQ-011 SHALL have ports: user_in  in  4  user digit value 0x0..0xF.
REQ-012 SHALL have ports: lfsr_out  out  7  segments {g,f,e,d,c,b,a}, active-high, of the OTP digit selected by an.
REQ-013 SHALL have ports: user_out  out  7  segments of the entered digit selected by an.
REQ-014 SHALL have ports: an  out  DIGITS  one-hot digit select, active-high.
REQ-015 SHALL have ports: otp_val  out  W  captured OTP register, for scoreboarding.
REQ-016 SHALL have ports: pass, fail, locked, busy  out  1 each  session status.
REQ-017 SHALL have ports: attempts  out  4  current failed-attempt count.

Function
REQ-018 SHALL advance the LFSR every clock: next = {lfsr[W-2:0], ^(lfsr & TAPS)}.
REQ-019 SHALL implement states IDLE, ENTRY, CHECK, RESULT, LOCKED; busy = 1 in ENTRY and CHECK.
REQ-020 IDLE/RESULT: otp_latch -> otp_val <= current lfsr, otp_valid <= 1, entry buffer cleared, idx <= 0, pass/fail <= 0, -> ENTRY; user_latch ignored.
REQ-021 ENTRY: user_latch -> digit idx <= user_in, entered[idx] <= 1, idx++; latch at idx = DIGITS-1 -> CHECK.
REQ-022 ENTRY: otp_latch -> re-capture OTP, clear buffer, idx <= 0, stay ENTRY; attempts unchanged.
REQ-023 Simultaneous otp_latch and user_latch: otp_latch SHALL win; user digit discarded.
REQ-024 CHECK (one cycle): match -> pass <= 1, attempts <= 0, -> RESULT; mismatch -> attempts++, then attempts = MAX_ATTEMPTS -> LOCKED else fail <= 1, -> RESULT.
REQ-025 pass/fail SHALL rise at the 2nd rising edge after the edge sampling the final user_latch, holding until the next otp_latch or reset.
REQ-026 LOCKED: locked = 1, fail = 1, both latches ignored for exactly LOCK_CYCLES clocks, then attempts <= 0, fail <= 0, otp_valid <= 0, -> IDLE.
REQ-027 Digit i SHALL be otp_val[4i+3:4i] and entry slot i; digit 0 is the first entered.
REQ-028 Scan index SHALL advance every SCAN_DIV clocks, wrapping DIGITS-1 -> 0; an = 1 << index.
REQ-029 Segment encoding: hex 0-F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-030 lfsr_out SHALL be 7'h00 when otp_valid = 0; user_out SHALL be 7'h00 for slots with entered = 0.
REQ-031 All outputs SHALL be registered or decoded from registers only; no input-to-output combinational path.

Reset
REQ-032 reset SHALL force: state IDLE, lfsr = SEED, otp_val = 0, otp_valid = 0, buffer and entered cleared, idx = 0, attempts = 0, pass = fail = locked = 0, scan index 0 (an = 1), lfsr_out = user_out = 0.
REQ-033 reset asserted mid-session or mid-lockout SHALL take priority over all inputs and abort that session/lockout.

Verification (DIGITS=4, SEED=16'hACE1, TAPS=16'hB400, MAX_ATTEMPTS=3, LOCK_CYCLES=8, SCAN_DIV=1)
REQ-034 Reset then release, idle 4 clocks -> all outputs zero except an cycling 1,2,4,8,1; lfsr matches model.
REQ-035 otp_latch, then enter the 4 otp_val nibbles in digit order -> pass = 1 exactly 2 edges after 4th latch, attempts = 0, busy = 0.
REQ-036 Three sessions each entering 4'hF x4 against a non-FFFF OTP -> attempts 1, 2, then locked = 1 for 8 clocks with latches ignored, then IDLE with attempts = 0.
REQ-037 otp_latch and user_latch in the same cycle after 2 digits entered -> new otp_val, idx = 0, user_out all 7'h00, attempts unchanged.
REQ-038 reset asserted during LOCKED cycle 3 -> next cycle locked = 0, attempts = 0, state IDLE.
REQ-039 Enter 2 digits 4'h1, 4'hA -> user_out shows 06 at an = 1, 77 at an = 2, 00 at an = 4 and 8.

Source files
------------

// File: rtl/otp_auth_core.sv
// One-time-password authentication core: free-running LFSR supplies the OTP,
// the user enters it digit by digit, and repeated failures trigger a timed lockout.
module otp_auth_core #(
  parameter int                  DIGITS       = 4,
  parameter logic [4*DIGITS-1:0] SEED         = 16'hACE1,
  parameter logic [4*DIGITS-1:0] TAPS         = 16'hB400,
  parameter int                  MAX_ATTEMPTS = 3,
  parameter int                  LOCK_CYCLES  = 1000,
  parameter int                  SCAN_DIV     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  otp_latch,
  input  logic                  user_latch,
  input  logic [3:0]            user_in,
  output logic [6:0]            lfsr_out,
  output logic [6:0]            user_out,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   otp_val,
  output logic                  pass,
  output logic                  fail,
  output logic                  locked,
  output logic                  busy,
  output logic [3:0]            attempts,
  output logic [2:0]            state_dbg
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_CHECK  = 3'd2,
    S_RESULT = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t          state;
  logic [W-1:0]    lfsr;
  logic            otp_valid;
  logic [W-1:0]    entry_buf;
  logic [DIGITS-1:0] entered;
  logic [IW-1:0]   idx;
  logic [LW-1:0]   lock_cnt;
  logic [IW-1:0]   scan_idx;
  logic [DW-1:0]   div_cnt;

  // otp_latch is only honoured where a new session may start; it beats user_latch.
  logic start_session;
  assign start_session = otp_latch &&
                         (state == S_IDLE || state == S_RESULT || state == S_ENTRY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      otp_val   <= '0;
      otp_valid <= 1'b0;
      entry_buf <= '0;
      entered   <= '0;
      idx       <= '0;
      attempts  <= 4'd0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      lock_cnt  <= '0;
      scan_idx  <= '0;
      div_cnt   <= '0;
    end else begin
      lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS)};

      if (div_cnt == DW'(SCAN_DIV - 1)) begin
        div_cnt  <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (start_session) begin
        otp_val   <= lfsr;
        otp_valid <= 1'b1;
        entry_buf <= '0;
        entered   <= '0;
        idx       <= '0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        state     <= S_ENTRY;
      end else begin
        case (state)
          S_ENTRY: begin
            if (user_latch) begin
              entry_buf[idx*4 +: 4] <= user_in;
              entered[idx]          <= 1'b1;
              idx                   <= idx + 1'b1;
              if (idx == IW'(DIGITS - 1)) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (entry_buf == otp_val) begin
              pass     <= 1'b1;
              attempts <= 4'd0;
              state    <= S_RESULT;
            end else begin
              attempts <= attempts + 4'd1;
              fail     <= 1'b1;
              if (attempts + 4'd1 == 4'(MAX_ATTEMPTS)) begin
                lock_cnt <= '0;
                state    <= S_LOCKED;
              end else begin
                state <= S_RESULT;
              end
            end
          end
          S_LOCKED: begin
            // Lockout ends after exactly LOCK_CYCLES clocks spent in this state.
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
              attempts  <= 4'd0;
              fail      <= 1'b0;
              otp_valid <= 1'b0;
              state     <= S_IDLE;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  // Display and status outputs are pure decodes of registered state.
  always_comb begin
    an        = DIGITS'(1) << scan_idx;
    lfsr_out  = otp_valid ? seg7(otp_val[scan_idx*4 +: 4]) : 7'h00;
    user_out  = entered[scan_idx] ? seg7(entry_buf[scan_idx*4 +: 4]) : 7'h00;
    busy      = (state == S_ENTRY) || (state == S_CHECK);
    locked    = (state == S_LOCKED);
    state_dbg = state;
  end

endmodule

// File: tb/tb_otp_auth_core.sv
// Bench for otp_auth_core: session results go through an expected-result queue,
// display, lockout and reset behaviour are checked cycle by cycle.
module tb_otp_auth_core;

  localparam int          DIGITS = 4;
  localparam int          W      = 16;
  localparam int          MAXA   = 3;
  localparam int          LOCKC  = 8;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [1:0]  R_PASS = 2'd1;
  localparam logic [1:0]  R_FAIL = 2'd2;
  localparam logic [1:0]  R_LOCK = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        otp_latch = 1'b0;
  logic        user_latch = 1'b0;
  logic [3:0]  user_in = 4'h0;
  logic [6:0]  lfsr_out, user_out;
  logic [3:0]  an;
  logic [15:0] otp_val;
  logic        pass, fail, locked, busy;
  logic [3:0]  attempts;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [1:0]   exp_q[$];
  logic [W-1:0] m_lfsr;
  logic [W-1:0] exp_otp;
  logic [3:0]   exp_att;
  logic [W-1:0] held;
  logic         prev_rf = 1'b0;

  always #5 clk = ~clk;

  otp_auth_core #(
    .DIGITS(DIGITS), .SEED(SEED), .TAPS(TAPS),
    .MAX_ATTEMPTS(MAXA), .LOCK_CYCLES(LOCKC), .SCAN_DIV(1)
  ) dut (
    .clk(clk), .reset(reset), .otp_latch(otp_latch), .user_latch(user_latch),
    .user_in(user_in), .lfsr_out(lfsr_out), .user_out(user_out), .an(an),
    .otp_val(otp_val), .pass(pass), .fail(fail), .locked(locked), .busy(busy),
    .attempts(attempts), .state_dbg(state_dbg)
  );

  // Reference LFSR, stepped on the same edges as the design.
  always @(posedge clk) m_lfsr <= reset ? SEED : {m_lfsr[W-2:0], ^(m_lfsr & TAPS)};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  // Result monitor: every rising edge of pass|fail consumes one expected result.
  always @(negedge clk) begin
    logic [1:0] e;
    if ((pass | fail) && !prev_rf) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {locked, pass, fail}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", locked ? R_LOCK : (pass ? R_PASS : R_FAIL), e);
      end
    end
    prev_rf <= pass | fail;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic int an_index(input logic [3:0] a);
    an_index = -1;
    for (int j = 0; j < DIGITS; j++) if (a == (4'd1 << j)) an_index = j;
  endfunction

  task automatic start_session();
    exp_otp   = m_lfsr;
    otp_latch = 1'b1;
    cyc();
    otp_latch = 1'b0;
    chk("otp_val", otp_val, exp_otp);
    chk("busy_start", busy, 1);
    chk("pf_cleared", {pass, fail}, 0);
  endtask

  task automatic enter_digit(input logic [3:0] d);
    user_in    = d;
    user_latch = 1'b1;
    cyc();
    user_latch = 1'b0;
  endtask

  task automatic enter_code(input logic [W-1:0] code);
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1) begin
        if (code == exp_otp) begin
          exp_q.push_back(R_PASS);
          exp_att = 4'd0;
        end else if (exp_att + 4'd1 == 4'(MAXA)) begin
          exp_q.push_back(R_LOCK);
          exp_att = exp_att + 4'd1;
        end else begin
          exp_q.push_back(R_FAIL);
          exp_att = exp_att + 4'd1;
        end
      end
      enter_digit(code[4*i +: 4]);
    end
    chk("result_not_early", {pass, fail}, 0);
    chk("busy_check", busy, 1);
    cyc();
    chk("attempts", attempts, exp_att);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int j;
    exp_att = 4'd0;
    reset   = 1'b1;
    repeat (3) cyc();
    chk("rst_otp_val", otp_val, 0);
    chk("rst_status", {pass, fail, locked, busy}, 0);
    chk("rst_attempts", attempts, 0);
    chk("rst_an", an, 1);
    chk("rst_segs", {lfsr_out, user_out}, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;

    // Idle after reset: only the digit select moves.
    for (int k = 0; k < 5; k++) begin
      chk("idle_an", an, 4'd1 << (k % 4));
      chk("idle_segs", {lfsr_out, user_out}, 0);
      chk("idle_status", {pass, fail, locked, busy, attempts}, 0);
      if (k < 4) cyc();
    end

    // Correct entry passes; both displays then show the OTP.
    start_session();
    enter_code(exp_otp);
    chk("pass_held", pass, 1);
    for (int k = 0; k < DIGITS; k++) begin
      cyc();
      j = an_index(an);
      chk("an_onehot", (j >= 0), 1);
      if (j >= 0) begin
        chk("lfsr_seg", lfsr_out, seg7(exp_otp[4*j +: 4]));
        chk("user_seg", user_out, seg7(exp_otp[4*j +: 4]));
      end
    end

    // Partial entry display, then otp_latch colliding with user_latch.
    start_session();
    enter_digit(4'h1);
    enter_digit(4'hA);
    for (int k = 0; k < DIGITS; k++) begin
      j = an_index(an);
      chk("partial_seg", user_out, (j == 0) ? 7'h06 : (j == 1) ? 7'h77 : 7'h00);
      cyc();
    end
    exp_otp    = m_lfsr;
    otp_latch  = 1'b1;
    user_latch = 1'b1;
    user_in    = 4'h5;
    cyc();
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    chk("collide_otp", otp_val, exp_otp);
    chk("collide_att", attempts, exp_att);
    for (int k = 0; k < DIGITS; k++) begin
      chk("collide_user_out", user_out, 0);
      cyc();
    end
    enter_code(exp_otp);

    // Three failures lock the core out for LOCKC clocks.
    for (int s = 0; s < MAXA; s++) begin
      start_session();
      enter_code(16'hFFFF);
    end
    chk("lock_flags", {locked, fail, pass}, 3'b110);
    held = otp_val;
    for (int c = 0; c < LOCKC - 1; c++) begin
      otp_latch  = c[0];
      user_latch = ~c[0];
      user_in    = 4'(c);
      cyc();
      chk("lock_held", {locked, fail}, 2'b11);
      chk("lock_otp", otp_val, held);
    end
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    cyc();
    chk("unlock_flags", {locked, fail, pass}, 0);
    chk("unlock_att", attempts, 0);
    chk("unlock_state", state_dbg, 0);
    chk("unlock_lfsr_out", lfsr_out, 0);
    exp_att = 4'd0;

    start_session();
    enter_code(exp_otp);

    // Reset in the middle of a lockout.
    for (int s = 0; s < MAXA; s++) begin
      start_session();
      enter_code(16'hFFFF);
    end
    cyc();
    cyc();
    chk("lock_c3", locked, 1);
    reset = 1'b1;
    cyc();
    chk("abort_locked", {locked, fail, pass}, 0);
    chk("abort_att", attempts, 0);
    chk("abort_state", state_dbg, 0);
    chk("abort_otp", otp_val, 0);
    reset   = 1'b0;
    exp_att = 4'd0;

    start_session();
    enter_code(exp_otp);
    cyc();
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
